// File: rtl/booth_divider.sv
// Sequential signed non-restoring divider: one quotient bit per clock on a
// shared add/sub step, with a final remainder restore and sign fix-up.
module booth_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;          // signed partial remainder
    logic [WIDTH-1:0] q_q, q_d;          // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;          // divisor magnitude
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q_q, sgn_q_d;
    logic             sgn_r_q, sgn_r_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_step;
    logic [WIDTH:0]   p_fix;

    // Two's-complement negation of the most-negative value wraps to itself,
    // which is exactly the unsigned magnitude 2^(WIDTH-1).
    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

    assign p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign p_step  = p_shift[WIDTH] ? (p_shift + {1'b0, d_q})
                                    : (p_shift - {1'b0, d_q});
    assign p_fix   = p_q[WIDTH] ? (p_q + {1'b0, d_q}) : p_q;

    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        sgn_q_d = sgn_q_q;
        sgn_r_d = sgn_r_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = dvd_mag;
                        d_d     = dvs_mag;
                        p_d     = '0;
                        cnt_d   = CW'(WIDTH);
                        sgn_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sgn_r_d = dividend[WIDTH-1];
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // The sign after the add/sub is the restoring-division comparison result.
                p_d   = p_step;
                q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = CORR;
                end
            end
            CORR: begin
                p_d     = p_fix;
                quo_d   = sgn_q_q ? -q_q : q_q;
                rem_d   = sgn_r_q ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            sgn_q_q <= sgn_q_d;
            sgn_r_q <= sgn_r_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == CALC) || (state_q == CORR);

endmodule
